// File: rtl/dll_ctrl_pkg.sv
// Shared definitions for the DLL lock controller.
// - dll_state_e : FSM state encoding, also driven out on the 3-bit state port
// - DEF_*       : default parameter values used by dll_lock_ctrl and dll_settle_timer
package dll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_COARSE = 3'd2,
    ST_FINE   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAULT  = 3'd5
  } dll_state_e;

  localparam int DEF_CODE_W      = 8;
  localparam int DEF_INIT_CODE   = 128;
  localparam int DEF_COARSE_STEP = 8;
  localparam int DEF_SETTLE_CYC  = 4;
  localparam int DEF_LOCK_CNT    = 8;
  localparam int DEF_UNLOCK_RUN  = 4;

endpackage

// File: rtl/dll_settle_timer.sv
// Settle-wait counter for the DLL lock controller.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset
//   start - pulse on the cycle the FSM enters SETTLE (reloads the count)
//   done  - high on the last of the SETTLE_CYC cycles spent waiting
module dll_settle_timer
  import dll_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);

  localparam int CW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CW'(SETTLE_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count value 1 marks the final waiting cycle; a zero-length setting
  // still yields a one-cycle SETTLE.
  assign done = (cnt_q <= CW'(1));

endmodule

// File: rtl/dll_lock_ctrl.sv
// DLL lock controller: coarse search, fine +/-1 tracking, lock/unlock
// detection and saturation fault handling, driven by a registered
// phase-detector output.
// Ports:
//   clk        - clock
//   rst        - synchronous active-high reset
//   en         - loop enable; low forces IDLE and reloads INIT_CODE
//   pd_up      - phase detector (1 = increase delay, 0 = decrease)
//   delay_code - delay-line control code (registered)
//   locked     - lock indication (registered)
//   fault      - sticky saturation fault (registered)
//   state      - current FSM state encoding (registered)
module dll_lock_ctrl
  import dll_ctrl_pkg::*;
#(
  parameter int CODE_W      = DEF_CODE_W,
  parameter int INIT_CODE   = DEF_INIT_CODE,
  parameter int COARSE_STEP = DEF_COARSE_STEP,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int LOCK_CNT    = DEF_LOCK_CNT,
  parameter int UNLOCK_RUN  = DEF_UNLOCK_RUN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              pd_up,
  output logic [CODE_W-1:0] delay_code,
  output logic              locked,
  output logic              fault,
  output logic [2:0]        state
);

  localparam int CW1 = CODE_W + 1;
  localparam int RW  = $clog2(LOCK_CNT + 1);
  localparam int UW  = $clog2(UNLOCK_RUN + 1);
  localparam logic [CODE_W-1:0] CODE_INIT = CODE_W'(INIT_CODE);
  localparam logic [CODE_W-1:0] CODE_MAX  = '1;

  dll_state_e        state_q, state_d;
  dll_state_e        tgt_q, tgt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              locked_q, locked_d;
  logic              fault_q, fault_d;
  logic              prev_q, prev_d;
  logic              have_prev_q, have_prev_d;
  logic [RW-1:0]     rev_q, rev_d;
  logic [UW-1:0]     run_q, run_d;

  logic              settle_start, settle_done;
  logic [CW1-1:0]    up_sum;
  logic [CODE_W-1:0] coarse_up, coarse_dn, coarse_next, fine_next;
  logic              sat_hit, coarse_rev;
  logic [UW-1:0]     run_len;

  dll_settle_timer #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_settle (
    .clk  (clk),
    .rst  (rst),
    .start(settle_start),
    .done (settle_done)
  );

  always_comb begin
    up_sum      = {1'b0, code_q} + CW1'(COARSE_STEP);
    coarse_up   = up_sum[CODE_W] ? CODE_MAX : up_sum[CODE_W-1:0];
    coarse_dn   = ({1'b0, code_q} < CW1'(COARSE_STEP)) ? '0 : code_q - CODE_W'(COARSE_STEP);
    coarse_next = pd_up ? coarse_up : coarse_dn;
    fine_next   = pd_up ? code_q + CODE_W'(1) : code_q - CODE_W'(1);
    sat_hit     = (code_q == CODE_MAX && pd_up) || (code_q == '0 && !pd_up);
    coarse_rev  = have_prev_q && (pd_up != prev_q);
    // Length of the current same-direction run; the first LOCKED sample
    // always starts a run of one because run_q is cleared on entry.
    run_len     = (pd_up == prev_q) ? run_q + UW'(1) : UW'(1);
  end

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    code_d      = code_q;
    locked_d    = locked_q;
    fault_d     = fault_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    rev_d       = rev_q;
    run_d       = run_q;

    if (!en) begin
      state_d     = ST_IDLE;
      tgt_d       = ST_COARSE;
      code_d      = CODE_INIT;
      locked_d    = 1'b0;
      fault_d     = 1'b0;
      prev_d      = 1'b0;
      have_prev_d = 1'b0;
      rev_d       = '0;
      run_d       = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SETTLE;
          tgt_d   = ST_COARSE;
          code_d  = CODE_INIT;
        end
        ST_SETTLE: begin
          if (settle_done) state_d = tgt_q;
        end
        ST_COARSE, ST_FINE, ST_LOCKED: begin
          if (sat_hit) begin
            state_d  = ST_FAULT;
            fault_d  = 1'b1;
            locked_d = 1'b0;
          end else begin
            state_d     = ST_SETTLE;
            prev_d      = pd_up;
            have_prev_d = 1'b1;
            case (state_q)
              ST_COARSE: begin
                if (coarse_rev) begin
                  code_d = fine_next;
                  tgt_d  = ST_FINE;
                  rev_d  = '0;
                end else begin
                  code_d = coarse_next;
                  tgt_d  = ST_COARSE;
                end
              end
              ST_FINE: begin
                code_d = fine_next;
                tgt_d  = ST_FINE;
                if (pd_up != prev_q) begin
                  if (rev_q == RW'(LOCK_CNT - 1)) begin
                    tgt_d    = ST_LOCKED;
                    locked_d = 1'b1;
                    rev_d    = '0;
                    run_d    = '0;
                  end else begin
                    rev_d = rev_q + RW'(1);
                  end
                end else begin
                  rev_d = '0;
                end
              end
              default: begin
                code_d = fine_next;
                if (run_len == UW'(UNLOCK_RUN)) begin
                  tgt_d    = ST_FINE;
                  locked_d = 1'b0;
                  rev_d    = '0;
                  run_d    = '0;
                end else begin
                  tgt_d = ST_LOCKED;
                  run_d = run_len;
                end
              end
            endcase
          end
        end
        default: ; // FAULT holds everything until en drops
      endcase
    end
  end

  assign settle_start = (state_d == ST_SETTLE) && (state_q != ST_SETTLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tgt_q       <= ST_COARSE;
      code_q      <= CODE_INIT;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
      prev_q      <= 1'b0;
      have_prev_q <= 1'b0;
      rev_q       <= '0;
      run_q       <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      code_q      <= code_d;
      locked_q    <= locked_d;
      fault_q     <= fault_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      rev_q       <= rev_d;
      run_q       <= run_d;
    end
  end

  assign delay_code = code_q;
  assign locked     = locked_q;
  assign fault      = fault_q;
  assign state      = state_q;

endmodule

// File: tb/tb_dll_lock_ctrl.sv
// Self-checking bench for dll_lock_ctrl: directed scenarios plus a random
// pd_up walk, all compared against a sample-level reference model.
module tb_dll_lock_ctrl;

  localparam int M_IDLE   = 0;
  localparam int M_SETTLE = 1;
  localparam int M_COARSE = 2;
  localparam int M_FINE   = 3;
  localparam int M_LOCKED = 4;
  localparam int M_FAULT  = 5;

  logic       clk = 1'b0;
  logic       rst, en, pd_up, sel;
  logic [7:0] code0, code1, code_o;
  logic       lk0, lk1, ft0, ft1, lk_o, ft_o;
  logic [2:0] st0, st1, st_o;

  always #5 clk = ~clk;

  dll_lock_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .pd_up(pd_up),
    .delay_code(code0), .locked(lk0), .fault(ft0), .state(st0)
  );

  dll_lock_ctrl #(.INIT_CODE(250)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .pd_up(pd_up),
    .delay_code(code1), .locked(lk1), .fault(ft1), .state(st1)
  );

  always_comb begin
    code_o = sel ? code1 : code0;
    lk_o   = sel ? lk1 : lk0;
    ft_o   = sel ? ft1 : ft0;
    st_o   = sel ? st1 : st0;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: one update per pd_up sample, from the behavioural rules.
  int m_code, m_mode, m_last;
  bit m_locked, m_fault;
  bit phase[$];

  logic [2:0] samp_state, post_state;
  int         settle_n, pre_mode;

  task automatic model_init(input int init);
    m_code = init; m_mode = M_IDLE; m_last = -1;
    m_locked = 0; m_fault = 0; phase.delete();
  endtask

  task automatic model_apply(input bit up);
    int r;
    if ((m_code == 255 && up) || (m_code == 0 && !up)) begin
      m_mode = M_FAULT; m_fault = 1; m_locked = 0;
      return;
    end
    case (m_mode)
      M_COARSE: begin
        if (m_last >= 0 && int'(up) != m_last) begin
          m_code += up ? 1 : -1;
          m_mode = M_FINE;
          phase.delete(); phase.push_back(up);
        end else begin
          m_code += up ? 8 : -8;
          if (m_code > 255) m_code = 255;
          if (m_code < 0) m_code = 0;
        end
      end
      M_FINE: begin
        m_code += up ? 1 : -1;
        phase.push_back(up);
        r = 0;
        for (int i = phase.size() - 1; i > 0; i--)
          if (phase[i] != phase[i-1]) r++; else break;
        if (r >= 8) begin
          m_mode = M_LOCKED; m_locked = 1; phase.delete();
        end
      end
      M_LOCKED: begin
        m_code += up ? 1 : -1;
        phase.push_back(up);
        r = 1;
        for (int i = phase.size() - 1; i > 0; i--)
          if (phase[i] == phase[i-1]) r++; else break;
        if (r >= 4) begin
          m_mode = M_FINE; m_locked = 0;
          phase.delete(); phase.push_back(up);
        end
      end
      default: ;
    endcase
    m_last = int'(up);
  endtask

  // Counts cycles spent in SETTLE from the current negedge (bounded).
  task automatic count_settle();
    settle_n = 0;
    while (st_o == 3'(M_SETTLE) && settle_n < 10) begin
      settle_n++;
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic start_loop();
    en = 1'b1;
    @(posedge clk); @(negedge clk);
    post_state = st_o;
    count_settle();
    m_mode = M_COARSE;
  endtask

  // Called at the negedge of a sample cycle; returns at the next sample cycle.
  task automatic drive_sample(input bit up);
    pre_mode   = m_mode;
    samp_state = st_o;
    pd_up      = up;
    @(posedge clk);
    model_apply(up);
    @(negedge clk);
    post_state = st_o;
    count_settle();
  endtask

  task automatic do_reset(input bit s, input int init);
    sel = s; rst = 1'b1; en = 1'b0; pd_up = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b0;
    model_init(init);
  endtask

  task automatic test_reset();
    sel = 1'b0; model_init(128);
    rst = 1'b1; en = 1'b0; pd_up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      total_cnt++;
      if ({st_o, code_o, lk_o, ft_o} !== {3'd0, 8'd128, 1'b0, 1'b0})
        $display("FAIL reset_values cyc%0d: got st=%0d code=%0d lk=%b ft=%b, want st=0 code=128 lk=0 ft=0",
                 i, st_o, code_o, lk_o, ft_o);
      else pass_cnt++;
    end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    total_cnt++;
    if (st_o !== 3'd0) $display("FAIL idle_hold: got st=%0d, want 0", st_o);
    else pass_cnt++;
    start_loop();
    total_cnt++;
    if (post_state !== 3'd1 || settle_n != 4 || st_o !== 3'd2)
      $display("FAIL enable_settle: got first=%0d settle=%0d next=%0d, want 1 4 2", post_state, settle_n, st_o);
    else pass_cnt++;
  endtask

  task automatic test_coarse_to_fine();
    bit seq[4] = '{1, 1, 1, 0};
    int exp_code[4] = '{136, 144, 152, 151};
    logic [19:0] act_v, exp_v;
    for (int i = 0; i < 4; i++) begin
      drive_sample(seq[i]);
      act_v = {samp_state, post_state, code_o, lk_o, ft_o, 4'(settle_n)};
      exp_v = {3'(pre_mode), 3'(M_SETTLE), 8'(exp_code[i]), 1'b0, 1'b0, 4'd4};
      total_cnt++;
      if (act_v !== exp_v || code_o !== 8'(m_code))
        $display("FAIL coarse_sample%0d: got %h code=%0d, want %h code=%0d", i, act_v, code_o, exp_v, m_code);
      else pass_cnt++;
    end
    total_cnt++;
    if (st_o !== 3'(M_FINE)) $display("FAIL coarse_to_fine_state: got %0d, want 3", st_o);
    else pass_cnt++;
  endtask

  task automatic test_lock();
    logic [19:0] act_v, exp_v;
    for (int i = 0; i < 8; i++) begin
      drive_sample(((i % 2) == 0) ? 1'b1 : 1'b0);
      act_v = {samp_state, post_state, code_o, lk_o, ft_o, 4'(settle_n)};
      exp_v = {3'(pre_mode), 3'(M_SETTLE), 8'(m_code), m_locked, 1'b0, 4'd4};
      total_cnt++;
      if (act_v !== exp_v || lk_o !== (i == 7) || code_o !== (((i % 2) == 0) ? 8'd152 : 8'd151))
        $display("FAIL lock_sample%0d: got %h, want %h (locked only after 8th)", i, act_v, exp_v);
      else pass_cnt++;
    end
    total_cnt++;
    if (st_o !== 3'(M_LOCKED)) $display("FAIL lock_state: got %0d, want 4", st_o);
    else pass_cnt++;
  endtask

  task automatic test_unlock();
    logic [19:0] act_v, exp_v;
    for (int i = 0; i < 4; i++) begin
      drive_sample(1'b1);
      act_v = {samp_state, post_state, code_o, lk_o, ft_o, 4'(settle_n)};
      exp_v = {3'(pre_mode), 3'(M_SETTLE), 8'(m_code), m_locked, 1'b0, 4'd4};
      total_cnt++;
      if (act_v !== exp_v || code_o !== 8'(152 + i) || lk_o !== (i < 3))
        $display("FAIL unlock_sample%0d: got %h, want %h", i, act_v, exp_v);
      else pass_cnt++;
    end
    total_cnt++;
    if (st_o !== 3'(M_FINE)) $display("FAIL unlock_state: got %0d, want 3", st_o);
    else pass_cnt++;
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < 8; i++) drive_sample(((i % 2) == 0) ? 1'b0 : 1'b1);
    total_cnt++;
    if (lk_o !== 1'b1 || m_locked !== 1'b1 || st_o !== 3'(M_LOCKED))
      $display("FAIL relock: got lk=%b st=%0d, want lk=1 st=4", lk_o, st_o);
    else pass_cnt++;
    en = 1'b0; pd_up = 1'b1;
    @(posedge clk); @(negedge clk);
    total_cnt++;
    if ({st_o, code_o, lk_o, ft_o} !== {3'd0, 8'd128, 1'b0, 1'b0})
      $display("FAIL enable_drop: got st=%0d code=%0d lk=%b, want st=0 code=128 lk=0", st_o, code_o, lk_o);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [19:0] act_v, exp_v;
    bit up;
    model_init(128);
    start_loop();
    for (int i = 0; i < 60; i++) begin
      if (m_last < 0) up = 1'($urandom_range(0, 1));
      else up = ($urandom_range(0, 9) < 7) ? (m_last == 0) : (m_last == 1);
      drive_sample(up);
      act_v = {samp_state, post_state, code_o, lk_o, ft_o, 4'(settle_n)};
      exp_v = {3'(pre_mode), 3'((m_mode == M_FAULT) ? M_FAULT : M_SETTLE), 8'(m_code),
               m_locked, m_fault, 4'((m_mode == M_FAULT) ? 0 : 4)};
      total_cnt++;
      if (act_v !== exp_v)
        $display("FAIL random_sample%0d: got %h, want %h", i, act_v, exp_v);
      else pass_cnt++;
      if (m_mode == M_FAULT) break;
    end
  endtask

  task automatic test_saturation();
    logic [19:0] act_v, exp_v;
    do_reset(1'b1, 250);
    start_loop();
    for (int i = 0; i < 2; i++) begin
      drive_sample(1'b1);
      act_v = {samp_state, post_state, code_o, lk_o, ft_o, 4'(settle_n)};
      exp_v = {3'(pre_mode), 3'((i == 1) ? M_FAULT : M_SETTLE), 8'd255, 1'b0, 1'(i == 1), 4'((i == 1) ? 0 : 4)};
      total_cnt++;
      if (act_v !== exp_v || code_o !== 8'(m_code) || ft_o !== m_fault)
        $display("FAIL sat_sample%0d: got %h, want %h", i, act_v, exp_v);
      else pass_cnt++;
    end
    pd_up = 1'b0;
    repeat (6) begin @(posedge clk); @(negedge clk); end
    total_cnt++;
    if ({st_o, code_o, ft_o} !== {3'd5, 8'd255, 1'b1})
      $display("FAIL fault_hold: got st=%0d code=%0d ft=%b, want 5 255 1", st_o, code_o, ft_o);
    else pass_cnt++;
    en = 1'b0;
    @(posedge clk); @(negedge clk);
    total_cnt++;
    if ({st_o, code_o, lk_o, ft_o} !== {3'd0, 8'd250, 1'b0, 1'b0})
      $display("FAIL fault_exit: got st=%0d code=%0d ft=%b, want 0 250 0", st_o, code_o, ft_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0, 128);
    start_loop();
    drive_sample(1'b1);
    drive_sample(1'b0);
    for (int i = 0; i < 8; i++) drive_sample(((i % 2) == 0) ? 1'b1 : 1'b0);
    pd_up = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    total_cnt++;
    if (st_o !== 3'd1 || lk_o !== 1'b1)
      $display("FAIL pre_mid_reset: got st=%0d lk=%b, want st=1 lk=1", st_o, lk_o);
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    total_cnt++;
    if ({st_o, code_o, lk_o, ft_o} !== {3'd0, 8'd128, 1'b0, 1'b0})
      $display("FAIL mid_reset: got st=%0d code=%0d lk=%b ft=%b, want 0 128 0 0", st_o, code_o, lk_o, ft_o);
    else pass_cnt++;
    rst = 1'b0;
    model_init(128);
    start_loop();
    drive_sample(1'b0);
    total_cnt++;
    if (code_o !== 8'd120 || code_o !== 8'(m_code) || samp_state !== 3'd2)
      $display("FAIL post_reset_prev_cleared: got code=%0d st=%0d, want code=120 st=2", code_o, samp_state);
    else pass_cnt++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no completion, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; rst = 1'b1; en = 1'b0; pd_up = 1'b0;
    @(negedge clk);
    test_reset();
    test_coarse_to_fine();
    test_lock();
    test_unlock();
    test_enable_drop();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dll_lock_ctrl.md
DLL_LOCK_CTRL -- requirements
Module: dll_lock_ctrl

Interface
REQ-001 The block SHALL have parameter CODE_W, default 8, meaning delay-code width.
REQ-002 The block SHALL have parameter INIT_CODE, default 128, meaning the code loaded on reset or disable.
REQ-003 The block SHALL have parameter COARSE_STEP, default 8, meaning the coarse-search code increment.
REQ-004 The block SHALL have parameter SETTLE_CYC, default 4, meaning the wait in cycles between a code change and the next pd_up sample.
REQ-005 The block SHALL have parameter LOCK_CNT, default 8, meaning the consecutive direction reversals required to declare lock.
REQ-006 The block SHALL have parameter UNLOCK_RUN, default 4, meaning the consecutive same-direction samples that drop lock.
REQ-007 The block SHALL have port clk, input, 1 bit, the single clock; one clock; reset is synchronous and active-high.
REQ-008 The block SHALL have port rst, input, 1 bit, the synchronous active-high reset.
REQ-009 The block SHALL have port en, input, 1 bit, the loop enable.
REQ-010 The block SHALL have port pd_up, input, 1 bit, the registered phase-detector output (1 = increase delay, 0 = decrease).
REQ-011 The block SHALL have port delay_code, output, CODE_W bits, the delay-line control code.
REQ-012 The block SHALL have port locked, output, 1 bit, the lock indication.
REQ-013 The block SHALL have port fault, output, 1 bit, the saturation fault flag (sticky).
REQ-014 The block SHALL have port state, output, 3 bits, the current FSM state encoding.

Function
REQ-015 The FSM SHALL have states IDLE, SETTLE, COARSE, FINE, LOCKED and FAULT.
REQ-016 IDLE SHALL hold delay_code=INIT_CODE; en=1 SHALL move the FSM to SETTLE on the next cycle with the return target COARSE.
REQ-017 SETTLE SHALL count SETTLE_CYC cycles after any code change, then enter the return target; pd_up is sampled only on the first cycle of COARSE, FINE or LOCKED.
REQ-018 Each COARSE, FINE or LOCKED sample SHALL update the code exactly once, then re-enter SETTLE, giving one update per SETTLE_CYC+1 cycles.
REQ-019 COARSE SHALL add or subtract COARSE_STEP by pd_up, saturating at 0 and 2^CODE_W-1; the first sample whose pd_up differs from the previous COARSE sample SHALL instead step 1 in the new direction and target FINE.
REQ-020 FINE SHALL step the code by ±1 per sample and count consecutive reversals (pd_up != previous sample); a same-direction sample SHALL clear the count.
REQ-021 When the reversal count reaches LOCK_CNT, the FSM SHALL target LOCKED and assert locked in the same cycle the transition is registered.
REQ-022 LOCKED SHALL keep ±1 tracking and count consecutive same-direction samples; at UNLOCK_RUN the block SHALL deassert locked, clear the counters and target FINE.
REQ-023 A sample with delay_code=2^CODE_W-1 and pd_up=1, or delay_code=0 and pd_up=0, in any tracking state SHALL enter FAULT, set fault=1, clear locked and freeze delay_code.
REQ-024 FAULT SHALL be left only when en=0, going to IDLE, clearing fault and reloading INIT_CODE.
REQ-025 en=0 in any state SHALL force IDLE on the next cycle, clear locked and reload INIT_CODE, taking priority over any simultaneous sample.
REQ-026 All outputs SHALL be registered, with no combinational path from pd_up to any output.

Reset
REQ-027 rst=1 at a clock edge SHALL force state=IDLE, delay_code=INIT_CODE, locked=0, fault=0, and clear all counters and the previous-sample register, including mid-SETTLE or in FAULT.
REQ-028 rst SHALL take priority over en and pd_up.

Structure
REQ-029 Package dll_ctrl_pkg SHALL hold the state enum (IDLE=0, SETTLE=1, COARSE=2, FINE=3, LOCKED=4, FAULT=5) and the default parameter constants.
REQ-030 The SETTLE counter SHALL be the sub-module dll_settle_timer, with inputs start and SETTLE_CYC and output done.

Verification
REQ-031 Reset/enable test: rst high 3 cycles, then en=1 -> delay_code=128 and state=IDLE during reset; SETTLE for 4 cycles, then COARSE.
REQ-032 Coarse-to-fine test: pd_up=1 for 3 samples, then 0 -> code 128→136→144→152→151, then state=FINE.
REQ-033 Lock test: pd_up alternates in FINE for 8 samples -> locked=1 after the 8th reversal, with code oscillating ±1.
REQ-034 Unlock test: in LOCKED, pd_up=1 for 4 samples -> locked falls after the 4th sample, state=FINE, code +4.
REQ-035 Saturation test: INIT_CODE=250, pd_up=1 constant -> code 250→255 (clamped), next sample gives FAULT, fault=1, code held at 255; en=0 -> IDLE, code=250, fault=0.
REQ-036 Reset mid-operation test: rst asserted mid-SETTLE while LOCKED -> all outputs return to reset values on the next cycle.
